// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // x is XOR of data and received parity bit; odd mode expects 1, even expects 0
   function automatic logic par_err(input logic x, input int mode);
      if (mode == PARITY_ODD)  return ~x;
      if (mode == PARITY_EVEN) return x;
      return 1'b0;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receive-side word handshake between the UART receiver and its consumer.
interface uart_rx_cfg_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport master (output data, valid, parity_err, frame_err, overrun, input ready);
   modport slave  (input data, valid, parity_err, frame_err, overrun, output ready);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the async rx line; resets to the idle (high) level.
module uart_sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx_cfg.sv
// Parameterised UART receiver: mid-bit sampling, optional parity, 1-2 stop bits,
// single-entry output holding register with overrun reporting.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 10000000,
   parameter int BAUDRATE  = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int CPB = CLK_FREQ / BAUDRATE;
   localparam int CW  = $clog2(CPB + 1);
   localparam int IW  = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF      = CW'(CPB / 2);
   localparam logic [CW-1:0] LAST      = CW'(CPB - 1);
   localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   logic                 rx_s;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [IW-1:0]        bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 perr_r;
   logic                 ferr_r;
   logic                 wait_high;

   uart_sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         stop_idx   <= 1'b0;
         shreg      <= '0;
         perr_r     <= 1'b0;
         ferr_r     <= 1'b0;
         wait_high  <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               cnt <= '0;
               // After a frame ending low (break), the line must go idle before a new start
               if (wait_high) begin
                  if (rx_s) wait_high <= 1'b0;
               end else if (!rx_s) begin
                  state <= ST_START;
               end
            end

            ST_START: begin
               if (cnt == HALF) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  stop_idx <= 1'b0;
                  perr_r   <= 1'b0;
                  ferr_r   <= 1'b0;
                  state    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_DATA: begin
               if (cnt == LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT)
                     state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                  else
                     bit_idx <= bit_idx + IW'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_PARITY: begin
               if (cnt == LAST) begin
                  cnt    <= '0;
                  perr_r <= par_err(^shreg ^ rx_s, PARITY);
                  state  <= ST_STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            ST_STOP: begin
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (!rx_s) ferr_r <= 1'b1;
                  if (stop_idx == LAST_STOP) begin
                     state     <= ST_IDLE;
                     wait_high <= ~rx_s;
                     // Load when the slot is free or is being emptied this very cycle
                     if (!out_valid || out_ready) begin
                        out_valid  <= 1'b1;
                        out_data   <= shreg;
                        parity_err <= perr_r;
                        frame_err  <= ferr_r | ~rx_s;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     stop_idx <= stop_idx + 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
